rggen_apb_bridge: RTL and testbench

- APB initiator bridge: accepts single register accesses on an `rggen_bus_if` slave port and issues each as one APB3/APB4 transfer on an `rggen_apb_if` master port.
- Returns read data and a completion status to the requester.
- Sits between an internal register-bus fabric and an external or downstream APB register block, so a locally generated access can reach a block whose host interface is APB.

---
 rtl/rggen_rtl_pkg.sv | 24 ++
 rtl/rggen_apb_if.sv | 30 +++
 rtl/rggen_bus_if.sv | 30 +++
 rtl/rggen_apb_bridge.sv | 114 +++++++++++
 tb/tb_rggen_apb_bridge.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types: access direction, response status
// and the APB bridge state encoding.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } rggen_apb_bridge_state;

endpackage

// File: rtl/rggen_apb_if.sv
// APB3/APB4 bus: psel/penable/paddr/pprot/pwrite/pwdata/pstrb from
// the master, pready/prdata/pslverr from the completer.
interface rggen_apb_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [2:0]               pprot;
  logic                     pwrite;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic [BUS_WIDTH/8-1:0]   pstrb;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pprot,
    output pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pprot,
    input  pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/rggen_bus_if.sv
// Internal register bus: request/address/direction/write_data/strobe
// towards the slave, done/read_data/status back to the master.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  import rggen_rtl_pkg::*;

  logic                       request;
  logic [ADDRESS_WIDTH-1:0]   address;
  rggen_direction             direction;
  logic [BUS_WIDTH-1:0]       write_data;
  logic [BUS_WIDTH/8-1:0]     write_strobe;
  logic                       done;
  logic [BUS_WIDTH-1:0]       read_data;
  rggen_status                status;

  modport master (
    output request, address, direction,
    output write_data, write_strobe,
    input  done, read_data, status
  );

  modport slave (
    input  request, address, direction,
    input  write_data, write_strobe,
    output done, read_data, status
  );

endinterface

// File: rtl/rggen_apb_bridge.sv
// Bridges one rggen_bus_if access into one APB transfer (clk, rst,
// bus_if slave, apb_if master). RGGEN_APB_BRIDGE_TIMEOUT_EN adds an ACCESS timeout.
module rggen_apb_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
)(
  input logic         clk,
  input logic         rst,
  rggen_bus_if.slave  bus_if,
  rggen_apb_if.master apb_if
);

  localparam int SW = DATA_WIDTH / 8;

  rggen_apb_bridge_state    state;
  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic                     pwrite;
  logic [DATA_WIDTH-1:0]    pwdata;
  logic [SW-1:0]            pstrb;
  logic                     done;
  logic [DATA_WIDTH-1:0]    read_data;
  rggen_status              status;

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // last ACCESS cycle before giving up
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] count;
`endif

  assign apb_if.psel    = psel;
  assign apb_if.penable = penable;
  assign apb_if.paddr   = paddr;
  assign apb_if.pprot   = 3'b000;
  assign apb_if.pwrite  = pwrite;
  assign apb_if.pwdata  = pwdata;
  assign apb_if.pstrb   = pstrb;

  assign bus_if.done      = done;
  assign bus_if.read_data = read_data;
  assign bus_if.status    = status;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      done      <= 1'b0;
      read_data <= '0;
      status    <= RGGEN_OKAY;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
      count     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus_if.request) begin
            state  <= SETUP;
            psel   <= 1'b1;
            paddr  <= bus_if.address;
            pwrite <= bus_if.direction == RGGEN_WRITE;
            pwdata <= bus_if.write_data;
            pstrb  <= (bus_if.direction == RGGEN_WRITE)
                    ? bus_if.write_strobe : '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
          count   <= '0;
`endif
        end
        ACCESS: begin
          if (apb_if.pready) begin
            state     <= DONE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            done      <= 1'b1;
            read_data <= pwrite ? '0 : apb_if.prdata;
            status    <= apb_if.pslverr
                       ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
          end
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
          else if (count == LAST) begin
            state     <= DONE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            done      <= 1'b1;
            read_data <= '0;
            status    <= RGGEN_SLAVE_ERROR;
          end else begin
            count <= count + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Randomized scoreboard bench for rggen_apb_bridge with an APB
// responder model; honours RGGEN_APB_BRIDGE_TIMEOUT_EN.
module tb_rggen_apb_bridge;
  import rggen_rtl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  localparam int TO   = 4;
  localparam int MAXW = 7;
`else
  localparam int TO   = 0;
  localparam int MAXW = 5;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    bit            write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            waits;
    logic [DW-1:0] rdata;
    bit            err;
    int            base;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus_if();
  rggen_apb_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) apb_if();

  rggen_apb_bridge #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO > 0 ? TO : 256)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_if(bus_if),
    .apb_if(apb_if)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  txn_t resp_q[$];
  txn_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: what the requester should see for a transaction.
  function automatic void model(input txn_t t,
                                output logic [DW-1:0] rd,
                                output logic [1:0] st,
                                output int lat);
    if (TO > 0 && t.waits >= TO) begin
      rd  = '0;
      st  = 2'b10;
      lat = 2 + TO;
    end else begin
      rd  = t.write ? '0 : t.rdata;
      st  = t.err ? 2'b10 : 2'b00;
      lat = 3 + t.waits;
    end
  endfunction

  function automatic logic [63:0] apb_exp(input txn_t t);
    logic [SW-1:0] s;
    s = t.write ? t.strb : '0;
    return 64'({t.addr, t.write, t.wdata, s, 3'b000});
  endfunction

  function automatic logic [63:0] apb_act();
    return 64'({apb_if.paddr, apb_if.pwrite, apb_if.pwdata,
                apb_if.pstrb, apb_if.pprot});
  endfunction

  // APB completer: pops a transaction at SETUP, inserts its wait
  // states, and drives noise on pready/prdata outside ACCESS.
  txn_t cur;
  bit   active = 0;
  int   acnt   = 0;
  always @(negedge clk) begin
    if (rst) begin
      active         = 0;
      apb_if.pready  = 1'b0;
      apb_if.prdata  = '0;
      apb_if.pslverr = 1'b0;
    end else begin
      check("penable_without_psel",
            64'(apb_if.penable & ~apb_if.psel), 64'd0);
      if (apb_if.psel && !apb_if.penable) begin
        if (resp_q.size() == 0) begin
          check("unexpected_setup", 64'd1, 64'd0);
        end else begin
          cur    = resp_q.pop_front();
          active = 1;
          acnt   = 0;
          check("setup_cycle", 64'(cyc), 64'(cur.base + 1));
          check("apb_fields_setup", apb_act(), apb_exp(cur));
        end
        apb_if.pready  = 1'($urandom_range(0, 1));
        apb_if.prdata  = $urandom;
        apb_if.pslverr = 1'($urandom_range(0, 1));
      end else if (apb_if.psel && apb_if.penable && active) begin
        acnt++;
        if (acnt == 1)
          check("access_cycle", 64'(cyc), 64'(cur.base + 2));
        check("apb_fields_access", apb_act(), apb_exp(cur));
        apb_if.pready  = acnt > cur.waits;
        apb_if.prdata  = apb_if.pready ? cur.rdata : $urandom;
        apb_if.pslverr = apb_if.pready ? cur.err
                       : 1'($urandom_range(0, 1));
      end else begin
        if (!apb_if.psel) active = 0;
        apb_if.pready  = 1'($urandom_range(0, 1));
        apb_if.prdata  = $urandom;
        apb_if.pslverr = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response monitor: compares each done pulse against the scoreboard.
  bit prev_done = 0;
  always @(negedge clk) begin
    txn_t          t;
    logic [DW-1:0] rd;
    logic [1:0]    st;
    int            lat;
    if (!rst && bus_if.done) begin
      check("done_single_cycle", 64'(prev_done), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        t = exp_q.pop_front();
        model(t, rd, st, lat);
        check("read_data", 64'(bus_if.read_data), 64'(rd));
        check("status", 64'(bus_if.status), 64'(st));
        check("latency", 64'(cyc - t.base), 64'(lat));
      end
    end
    prev_done = !rst && bus_if.done;
  end

  function automatic txn_t rand_txn(input int maxw);
    txn_t t;
    t.addr  = AW'($urandom);
    t.write = 1'($urandom_range(0, 1));
    t.wdata = $urandom;
    t.strb  = SW'($urandom);
    t.waits = $urandom_range(0, maxw);
    t.rdata = $urandom;
    t.err   = ($urandom_range(0, 3) == 0);
    t.base  = 0;
    return t;
  endfunction

  task automatic drive(input txn_t t);
    bus_if.request      = 1'b1;
    bus_if.address      = t.addr;
    bus_if.direction    = t.write ? RGGEN_WRITE : RGGEN_READ;
    bus_if.write_data   = t.wdata;
    bus_if.write_strobe = t.strb;
  endtask

  // Called on a negedge; returns on the negedge where done is seen
  // with request still high, so the caller may chain another access.
  task automatic issue(input txn_t t, input bit b2b);
    bit seen;
    t.base = b2b ? cyc + 1 : cyc;
    drive(t);
    resp_q.push_back(t);
    exp_q.push_back(t);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus_if.done;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    bus_if.request = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_apb"},
          64'({apb_if.psel, apb_if.penable, apb_exp_zero()}), 64'd0);
    check({nm, "_bus"},
          64'({bus_if.done, bus_if.read_data, bus_if.status}), 64'd0);
  endtask

  function automatic logic [63:0] apb_exp_zero();
    return apb_act();
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    txn_t t;
    int   dones;
    bit   seen;
    bus_if.request      = 1'b0;
    bus_if.address      = '0;
    bus_if.direction    = RGGEN_READ;
    bus_if.write_data   = '0;
    bus_if.write_strobe = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // zero-wait write
    t = '{addr: 16'h0010, write: 1, wdata: 32'hDEAD_BEEF,
          strb: 4'hF, waits: 0, rdata: 32'h0, err: 0, base: 0};
    issue(t, 0);
    idle();

    // read with 3 wait states, then error read held back-to-back
    t = '{addr: 16'h0020, write: 0, wdata: 32'hA5A5_0001,
          strb: 4'h3, waits: 3, rdata: 32'h1234_5678, err: 0, base: 0};
    issue(t, 0);
    t = '{addr: 16'h0030, write: 0, wdata: 32'h0,
          strb: 4'h0, waits: 1, rdata: 32'hCAFE_F00D, err: 1, base: 0};
    issue(t, 1);
    t = '{addr: 16'h0034, write: 1, wdata: 32'h0BAD_0BAD,
          strb: 4'h5, waits: 0, rdata: 32'h0, err: 1, base: 0};
    issue(t, 1);
    idle();

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    t = '{addr: 16'h0040, write: 0, wdata: 32'h0,
          strb: 4'h0, waits: 100, rdata: 32'h1111_2222, err: 0, base: 0};
    issue(t, 0);
    idle();
    t = '{addr: 16'h0044, write: 0, wdata: 32'h0,
          strb: 4'h0, waits: 3, rdata: 32'h3333_4444, err: 0, base: 0};
    issue(t, 0);
    idle();
`endif

    // randomized traffic, sometimes chained across done
    for (int i = 0; i < 40; i++) begin
      issue(rand_txn(MAXW), 0);
      while ($urandom_range(0, 1) == 1)
        issue(rand_txn(MAXW), 1);
      idle();
    end

    // stalled transfer abandoned by reset
    t = rand_txn(0);
    t.waits = 100000;
    t.base  = cyc;
    drive(t);
    resp_q.push_back(t);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = apb_if.penable;
    end
    check("reach_access", 64'(seen), 64'd1);
    dones = 0;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    @(negedge clk);
`else
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus_if.done) dones++;
    end
    check("no_done_without_timeout", 64'(dones), 64'd0);
`endif
    rst = 1'b1;
    bus_if.request = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid_access");
    rst = 1'b0;
    @(negedge clk);
    check("no_done_after_reset", 64'(bus_if.done), 64'd0);
    resp_q.delete();

    for (int i = 0; i < 4; i++) begin
      issue(rand_txn(MAXW), 0);
      idle();
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("responder_drained", 64'(resp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
